// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite response codes and slave FSM state types.
// Pure declarations: no latency or backpressure of its own.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE,
    W_HAVE_AW,
    W_HAVE_W,
    W_RESP
  } wr_state_t;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rd_state_t;

endpackage

// File: rtl/axi_lite_bytemem.sv
// Word array with one byte-enabled write port and one registered read port (1 cycle).
// No backpressure; a read on the same edge as a write to that word returns the old data.
module axi_lite_bytemem
  import axi_lite_pkg::*;
#(
  parameter int DEPTH      = 256,
  parameter int DATA_WIDTH = 32,
  parameter int IDX_W      = $clog2(DEPTH)
) (
  input  logic                    core_clk,
  input  logic                    arst_n,
  input  logic                    wr_en,
  input  logic [IDX_W-1:0]        wr_idx,
  input  logic [DATA_WIDTH-1:0]   wr_dat,
  input  logic [DATA_WIDTH/8-1:0] wr_strb,
  input  logic                    rd_en,
  input  logic [IDX_W-1:0]        rd_idx,
  output logic [DATA_WIDTH-1:0]   rd_dat
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge core_clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      rd_dat <= '0;
    end else begin
      if (wr_en) begin
        for (int b = 0; b < DATA_WIDTH/8; b++) begin
          if (wr_strb[b]) begin
            mem[wr_idx][b*8 +: 8] <= wr_dat[b*8 +: 8];
          end
        end
      end
      if (rd_en) begin
        rd_dat <= mem[rd_idx];
      end
    end
  end

endmodule

// File: rtl/axi_lite_sram_slave.sv
// AXI4-Lite SRAM slave: B one cycle after the later of AW/W, R one cycle after AR.
// Readies drop while a response is pending and return the cycle after its handshake.
module axi_lite_sram_slave
  import axi_lite_pkg::*;
#(
  parameter int          ADDR_WIDTH = 32,
  parameter int          DATA_WIDTH = 32,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          MEM_DEPTH  = 256
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  input  logic [ADDR_WIDTH-1:0]   S_AWADDR,
  input  logic [2:0]              S_AWPROT,
  input  logic                    S_AWVALID,
  output logic                    S_AWREADY,
  input  logic [DATA_WIDTH-1:0]   S_WDATA,
  input  logic [DATA_WIDTH/8-1:0] S_WSTRB,
  input  logic                    S_WVALID,
  output logic                    S_WREADY,
  output logic [1:0]              S_BRESP,
  output logic                    S_BVALID,
  input  logic                    S_BREADY,
  input  logic [ADDR_WIDTH-1:0]   S_ARADDR,
  input  logic [2:0]              S_ARPROT,
  input  logic                    S_ARVALID,
  output logic                    S_ARREADY,
  output logic [DATA_WIDTH-1:0]   S_RDATA,
  output logic [1:0]              S_RRESP,
  output logic                    S_RVALID,
  output logic                    S_RLAST,
  input  logic                    S_RREADY
);

  localparam int IDX_W  = $clog2(MEM_DEPTH);
  localparam int STRB_W = DATA_WIDTH/8;
  // One extra bit so an address below BASE_ADDR underflows into an out-of-range offset.
  localparam logic [ADDR_WIDTH:0] BASE_EXT = (ADDR_WIDTH+1)'(BASE_ADDR);
  localparam logic [ADDR_WIDTH:0] SPAN     = (ADDR_WIDTH+1)'(4*MEM_DEPTH);

  logic init_done;

  wr_state_t wr_state, wr_next;
  rd_state_t rd_state, rd_next;

  logic aw_rdy, w_rdy, ar_rdy;
  logic aw_hs, w_hs, ar_hs;
  logic commit;

  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic [DATA_WIDTH-1:0] w_dat_q;
  logic [STRB_W-1:0]     w_strb_q;
  logic [1:0]            bresp_q;
  logic [1:0]            rresp_q;
  logic                  rd_err_q;

  logic [ADDR_WIDTH-1:0] cmt_addr;
  logic [DATA_WIDTH-1:0] cmt_dat;
  logic [STRB_W-1:0]     cmt_strb;
  logic [ADDR_WIDTH:0]   cmt_off, ar_off;
  logic                  cmt_ok, ar_ok;
  logic [DATA_WIDTH-1:0] mem_rd_dat;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      init_done <= 1'b0;
    end else begin
      init_done <= 1'b1;
    end
  end

  assign aw_rdy = init_done && (wr_state == W_IDLE || wr_state == W_HAVE_W);
  assign w_rdy  = init_done && (wr_state == W_IDLE || wr_state == W_HAVE_AW);
  assign ar_rdy = init_done && (rd_state == R_IDLE);
  assign aw_hs  = S_AWVALID && aw_rdy;
  assign w_hs   = S_WVALID && w_rdy;
  assign ar_hs  = S_ARVALID && ar_rdy;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wr_state <= W_IDLE;
      rd_state <= R_IDLE;
    end else begin
      wr_state <= wr_next;
      rd_state <= rd_next;
    end
  end

  always_comb begin
    wr_next = wr_state;
    case (wr_state)
      W_IDLE: begin
        if (aw_hs && w_hs)  wr_next = W_RESP;
        else if (aw_hs)     wr_next = W_HAVE_AW;
        else if (w_hs)      wr_next = W_HAVE_W;
      end
      W_HAVE_AW: if (w_hs)     wr_next = W_RESP;
      W_HAVE_W:  if (aw_hs)    wr_next = W_RESP;
      W_RESP:    if (S_BREADY) wr_next = W_IDLE;
      default:                 wr_next = W_IDLE;
    endcase
  end

  always_comb begin
    rd_next = rd_state;
    case (rd_state)
      R_IDLE:  if (ar_hs)    rd_next = R_DATA;
      R_DATA:  if (S_RREADY) rd_next = R_IDLE;
      default:               rd_next = R_IDLE;
    endcase
  end

  // The half that arrived first comes from its latch, the other straight off the bus.
  assign commit   = (wr_next == W_RESP) && (wr_state != W_RESP);
  assign cmt_addr = (wr_state == W_HAVE_AW) ? aw_addr_q : S_AWADDR;
  assign cmt_dat  = (wr_state == W_HAVE_W)  ? w_dat_q   : S_WDATA;
  assign cmt_strb = (wr_state == W_HAVE_W)  ? w_strb_q  : S_WSTRB;

  assign cmt_off = {1'b0, cmt_addr} - BASE_EXT;
  assign cmt_ok  = cmt_off < SPAN;
  assign ar_off  = {1'b0, S_ARADDR} - BASE_EXT;
  assign ar_ok   = ar_off < SPAN;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      aw_addr_q <= '0;
      w_dat_q   <= '0;
      w_strb_q  <= '0;
      bresp_q   <= RESP_OKAY;
      rresp_q   <= RESP_OKAY;
      rd_err_q  <= 1'b0;
    end else begin
      if (aw_hs) aw_addr_q <= S_AWADDR;
      if (w_hs) begin
        w_dat_q  <= S_WDATA;
        w_strb_q <= S_WSTRB;
      end
      if (commit) bresp_q <= cmt_ok ? RESP_OKAY : RESP_SLVERR;
      if (ar_hs) begin
        rresp_q  <= ar_ok ? RESP_OKAY : RESP_SLVERR;
        rd_err_q <= !ar_ok;
      end
    end
  end

  axi_lite_bytemem #(
    .DEPTH      (MEM_DEPTH),
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_W      (IDX_W)
  ) u_mem (
    .core_clk (ACLK),
    .arst_n   (ARESETN),
    .wr_en    (commit && cmt_ok),
    .wr_idx   (cmt_off[IDX_W+1:2]),
    .wr_dat   (cmt_dat),
    .wr_strb  (cmt_strb),
    .rd_en    (ar_hs && ar_ok),
    .rd_idx   (ar_off[IDX_W+1:2]),
    .rd_dat   (mem_rd_dat)
  );

  assign S_AWREADY = aw_rdy;
  assign S_WREADY  = w_rdy;
  assign S_ARREADY = ar_rdy;
  assign S_BVALID  = (wr_state == W_RESP);
  assign S_BRESP   = bresp_q;
  assign S_RVALID  = (rd_state == R_DATA);
  assign S_RLAST   = S_RVALID;
  assign S_RRESP   = rresp_q;
  // Out-of-range reads leave the array's read register alone, so zero is forced here.
  assign S_RDATA   = rd_err_q ? '0 : mem_rd_dat;

  logic unused_bits;
  assign unused_bits = ^{S_AWPROT, S_ARPROT,
                         cmt_off[ADDR_WIDTH:IDX_W+2], cmt_off[1:0],
                         ar_off[ADDR_WIDTH:IDX_W+2], ar_off[1:0]};

endmodule

// File: tb/tb_axi_lite_sram_slave.sv
// Directed plus randomized bench for axi_lite_sram_slave against an array-based memory model.
module tb_axi_lite_sram_slave;

  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int          DEPTH = 256;

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic [31:0] S_AWADDR = '0;
  logic [2:0]  S_AWPROT = '0;
  logic        S_AWVALID = 1'b0;
  logic        S_AWREADY;
  logic [31:0] S_WDATA = '0;
  logic [3:0]  S_WSTRB = '0;
  logic        S_WVALID = 1'b0;
  logic        S_WREADY;
  logic [1:0]  S_BRESP;
  logic        S_BVALID;
  logic        S_BREADY = 1'b1;
  logic [31:0] S_ARADDR = '0;
  logic [2:0]  S_ARPROT = '0;
  logic        S_ARVALID = 1'b0;
  logic        S_ARREADY;
  logic [31:0] S_RDATA;
  logic [1:0]  S_RRESP;
  logic        S_RVALID;
  logic        S_RLAST;
  logic        S_RREADY = 1'b1;

  int checks = 0;
  int failures = 0;
  logic [31:0] model [DEPTH];

  axi_lite_sram_slave #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .BASE_ADDR  (BASE),
    .MEM_DEPTH  (DEPTH)
  ) dut (
    .ACLK      (ACLK),
    .ARESETN   (ARESETN),
    .S_AWADDR  (S_AWADDR),
    .S_AWPROT  (S_AWPROT),
    .S_AWVALID (S_AWVALID),
    .S_AWREADY (S_AWREADY),
    .S_WDATA   (S_WDATA),
    .S_WSTRB   (S_WSTRB),
    .S_WVALID  (S_WVALID),
    .S_WREADY  (S_WREADY),
    .S_BRESP   (S_BRESP),
    .S_BVALID  (S_BVALID),
    .S_BREADY  (S_BREADY),
    .S_ARADDR  (S_ARADDR),
    .S_ARPROT  (S_ARPROT),
    .S_ARVALID (S_ARVALID),
    .S_ARREADY (S_ARREADY),
    .S_RDATA   (S_RDATA),
    .S_RRESP   (S_RRESP),
    .S_RVALID  (S_RVALID),
    .S_RLAST   (S_RLAST),
    .S_RREADY  (S_RREADY)
  );

  always #5 ACLK = ~ACLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  function automatic bit in_rng(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + 32'(4*DEPTH));
  endfunction

  function automatic logic [1:0] exp_resp(input logic [31:0] a);
    return in_rng(a) ? 2'b00 : 2'b10;
  endfunction

  function automatic logic [31:0] exp_rdata(input logic [31:0] a);
    return in_rng(a) ? model[(a - BASE) / 4] : 32'h0;
  endfunction

  function automatic void model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    if (in_rng(a)) begin
      for (int b = 0; b < 4; b++) begin
        if (s[b]) model[(a - BASE) / 4][b*8 +: 8] = d[b*8 +: 8];
      end
    end
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
  endfunction

  function automatic logic [31:0] rand_addr();
    int k;
    k = int'($urandom_range(0, 9));
    if (k < 7)       return BASE + 32'($urandom_range(0, 4*DEPTH - 1));
    else if (k == 7) return BASE - 32'($urandom_range(1, 16));
    else if (k == 8) return BASE + 32'(4*DEPTH) + 32'($urandom_range(0, 15));
    else             return $urandom;
  endfunction

  // AW and W each go valid after their own delay; B is expected right after the later handshake.
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int aw_dly, input int w_dly, output logic [1:0] resp);
    bit aw_done = 0, w_done = 0, aw_now, w_now;
    int c = 0;
    while (!(aw_done && w_done) && c < 40) begin
      S_AWADDR  = a;
      S_WDATA   = d;
      S_WSTRB   = s;
      S_AWVALID = !aw_done && (c >= aw_dly);
      S_WVALID  = !w_done && (c >= w_dly);
      if (aw_done) check("awready_low_after_aw", 32'(S_AWREADY), 32'h0);
      if (w_done)  check("wready_low_after_w", 32'(S_WREADY), 32'h0);
      aw_now = S_AWVALID && S_AWREADY;
      w_now  = S_WVALID && S_WREADY;
      tick();
      aw_done = aw_done || aw_now;
      w_done  = w_done || w_now;
      c++;
    end
    S_AWVALID = 1'b0;
    S_WVALID  = 1'b0;
    check("wr_handshakes_done", 32'(aw_done && w_done), 32'h1);
    check("bvalid_latency", 32'(S_BVALID), 32'h1);
    resp = S_BRESP;
    tick();
    check("bvalid_drop", 32'(S_BVALID), 32'h0);
    check("wr_readies_back", 32'(S_AWREADY && S_WREADY), 32'h1);
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] data, output logic [1:0] resp);
    bit done = 0, now;
    int c = 0;
    S_ARADDR = a;
    while (!done && c < 40) begin
      S_ARVALID = 1'b1;
      now = S_ARREADY;
      tick();
      done = now;
      c++;
    end
    S_ARVALID = 1'b0;
    check("ar_handshake_done", 32'(done), 32'h1);
    check("rvalid_latency", 32'(S_RVALID), 32'h1);
    check("rlast", 32'(S_RLAST), 32'h1);
    data = S_RDATA;
    resp = S_RRESP;
    tick();
    check("rvalid_drop", 32'(S_RVALID), 32'h0);
    check("arready_back", 32'(S_ARREADY), 32'h1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_awready"}, 32'(S_AWREADY), 32'h0);
    check({tag, "_wready"},  32'(S_WREADY),  32'h0);
    check({tag, "_arready"}, 32'(S_ARREADY), 32'h0);
    check({tag, "_bvalid"},  32'(S_BVALID),  32'h0);
    check({tag, "_rvalid"},  32'(S_RVALID),  32'h0);
    check({tag, "_rlast"},   32'(S_RLAST),   32'h0);
    check({tag, "_bresp"},   32'(S_BRESP),   32'h0);
    check({tag, "_rresp"},   32'(S_RRESP),   32'h0);
    check({tag, "_rdata"},   S_RDATA,        32'h0);
  endtask

  initial begin
    logic [1:0]  resp, rresp;
    logic [31:0] rdata, old, a, d, ra, exp_d;
    logic [3:0]  s;

    model_clear();

    // Reset state, then readies one cycle after release.
    #12;
    check_all_zero("reset");
    #10;
    ARESETN = 1'b1;
    #1;
    check("ready_gated_by_init", 32'(S_AWREADY || S_WREADY || S_ARREADY), 32'h0);
    tick();
    check("ready_after_init", 32'({S_AWREADY, S_WREADY, S_ARREADY}), 32'h7);

    // Same-cycle AW+W.
    do_write(32'h1004, 32'hA000_0001, 4'hF, 0, 0, resp);
    model_write(32'h1004, 32'hA000_0001, 4'hF);
    check("t1_bresp", 32'(resp), 32'h0);
    do_read(32'h1004, rdata, rresp);
    check("t1_rdata", rdata, 32'hA000_0001);
    check("t1_rresp", 32'(rresp), 32'h0);

    // W first, AW three cycles later.
    do_write(32'h1008, 32'hB000_0002, 4'hF, 3, 0, resp);
    model_write(32'h1008, 32'hB000_0002, 4'hF);
    check("t2_bresp", 32'(resp), 32'h0);
    do_read(32'h1008, rdata, rresp);
    check("t2_rdata", rdata, 32'hB000_0002);

    // AW first, W two cycles later.
    do_write(32'h100C, 32'hC0DE_0003, 4'hF, 0, 2, resp);
    model_write(32'h100C, 32'hC0DE_0003, 4'hF);
    do_read(32'h100C, rdata, rresp);
    check("aw_first_rdata", rdata, exp_rdata(32'h100C));

    // Partial strobe.
    do_write(32'h1010, 32'h1122_3344, 4'hF, 0, 0, resp);
    model_write(32'h1010, 32'h1122_3344, 4'hF);
    do_write(32'h1010, 32'hFFFF_FFFF, 4'h5, 0, 0, resp);
    model_write(32'h1010, 32'hFFFF_FFFF, 4'h5);
    do_read(32'h1010, rdata, rresp);
    check("t3_rdata", rdata, 32'h11FF_33FF);
    check("t3_model", rdata, exp_rdata(32'h1010));

    // Zero-strobe no-op.
    do_write(32'h1010, 32'h0, 4'h0, 0, 0, resp);
    check("nostrb_bresp", 32'(resp), 32'h0);
    do_read(32'h1010, rdata, rresp);
    check("nostrb_rdata", rdata, 32'h11FF_33FF);

    // Out of range and range edges.
    do_write(32'h2000, 32'hDEAD_BEEF, 4'hF, 1, 0, resp);
    check("t4_bresp", 32'(resp), 32'h2);
    do_read(32'h2000, rdata, rresp);
    check("t4_rd_hi_resp", 32'(rresp), 32'h2);
    check("t4_rd_hi_data", rdata, 32'h0);
    do_read(32'h0FFC, rdata, rresp);
    check("t4_rd_lo_resp", 32'(rresp), 32'h2);
    check("t4_rd_lo_data", rdata, 32'h0);
    do_write(32'h13FF, 32'h5A5A_0FF0, 4'hF, 0, 0, resp);
    model_write(32'h13FF, 32'h5A5A_0FF0, 4'hF);
    check("last_word_bresp", 32'(resp), 32'h0);
    do_write(32'h1400, 32'h1234_5678, 4'hF, 0, 0, resp);
    check("past_end_bresp", 32'(resp), 32'h2);
    do_read(32'h13FC, rdata, rresp);
    check("last_word_rdata", rdata, 32'h5A5A_0FF0);
    do_read(32'h1000, rdata, rresp);
    check("first_word_untouched", rdata, exp_rdata(32'h1000));

    // Read and write of the same word on the same edge: read sees old data.
    old = exp_rdata(32'h1004);
    fork
      do_write(32'h1004, 32'h7777_8888, 4'hF, 0, 0, resp);
      do_read(32'h1004, rdata, rresp);
    join
    check("collision_old_data", rdata, old);
    model_write(32'h1004, 32'h7777_8888, 4'hF);
    do_read(32'h1004, rdata, rresp);
    check("collision_new_data", rdata, 32'h7777_8888);

    // Backpressure on both response channels.
    S_BREADY = 1'b0;
    S_RREADY = 1'b0;
    d = $urandom;
    exp_d = exp_rdata(32'h1020);
    S_AWADDR = 32'h1020; S_WDATA = d; S_WSTRB = 4'hF; S_ARADDR = 32'h1020;
    S_AWVALID = 1'b1; S_WVALID = 1'b1; S_ARVALID = 1'b1;
    tick();
    S_AWVALID = 1'b0; S_WVALID = 1'b0; S_ARVALID = 1'b0;
    model_write(32'h1020, d, 4'hF);
    for (int i = 0; i < 5; i++) begin
      check("bp_bvalid", 32'(S_BVALID), 32'h1);
      check("bp_rvalid", 32'(S_RVALID), 32'h1);
      check("bp_bresp", 32'(S_BRESP), 32'h0);
      check("bp_rdata", S_RDATA, exp_d);
      check("bp_readies_low", 32'(S_AWREADY || S_WREADY || S_ARREADY), 32'h0);
      tick();
    end
    S_BREADY = 1'b1;
    S_RREADY = 1'b1;
    tick();
    check("bp_single_b", 32'(S_BVALID), 32'h0);
    check("bp_single_r", 32'(S_RVALID), 32'h0);
    check("bp_readies_back", 32'({S_AWREADY, S_WREADY, S_ARREADY}), 32'h7);
    do_read(32'h1020, rdata, rresp);
    check("bp_readback", rdata, d);

    // Randomized traffic against the model.
    for (int i = 0; i < 60; i++) begin
      a = rand_addr();
      d = $urandom;
      s = 4'($urandom_range(0, 15));
      do_write(a, d, s, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), resp);
      check("rand_bresp", 32'(resp), 32'(exp_resp(a)));
      model_write(a, d, s);
      ra = ($urandom_range(0, 1) == 0) ? a : rand_addr();
      do_read(ra, rdata, rresp);
      check("rand_rresp", 32'(rresp), 32'(exp_resp(ra)));
      check("rand_rdata", rdata, exp_rdata(ra));
    end

    // Reset while a B and an R response are both pending.
    S_BREADY = 1'b0;
    S_RREADY = 1'b0;
    S_AWADDR = 32'h1030; S_WDATA = 32'hFEED_F00D; S_WSTRB = 4'hF; S_ARADDR = 32'h1004;
    S_AWVALID = 1'b1; S_WVALID = 1'b1; S_ARVALID = 1'b1;
    tick();
    S_AWVALID = 1'b0; S_WVALID = 1'b0; S_ARVALID = 1'b0;
    check("pre_rst_bvalid", 32'(S_BVALID), 32'h1);
    check("pre_rst_rvalid", 32'(S_RVALID), 32'h1);
    #2;
    ARESETN = 1'b0;
    #1;
    check_all_zero("midrst");
    tick();
    #3;
    ARESETN = 1'b1;
    #1;
    check("midrst_ready_gated", 32'(S_AWREADY || S_WREADY || S_ARREADY), 32'h0);
    tick();
    check("midrst_ready_back", 32'({S_AWREADY, S_WREADY, S_ARREADY}), 32'h7);
    S_BREADY = 1'b1;
    S_RREADY = 1'b1;
    model_clear();
    do_read(32'h1004, rdata, rresp);
    check("cleared_1004", rdata, exp_rdata(32'h1004));
    do_read(32'h1030, rdata, rresp);
    check("cleared_1030", rdata, 32'h0);
    do_read(32'h13FC, rdata, rresp);
    check("cleared_13fc", rdata, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi_lite_sram_slave.md
# axi_lite_sram_slave

AXI4-Lite memory slave that terminates one slave port (S0..S3) of `axi_rr_interconnect_2x4`, and gives the interconnect a realistic downstream consumer in place of always-ready tie-offs. It holds a word-addressed, byte-strobed memory of `MEM_DEPTH` words. Write address and write data may be accepted in either order, and each accepted write returns one B response. Reads return single-beat R responses. Out-of-range accesses return SLVERR.

## Interface
- `ADDR_WIDTH`, 32: address width.
- `DATA_WIDTH`, 32: data width; fixed at 32.
- `BASE_ADDR`, 32'h0000_0000: byte address of word 0.
- `MEM_DEPTH`, 256: number of 32-bit words; must be a power of 2.
- `ACLK` in 1: the single clock.
- `ARESETN` in 1: asynchronous, active-low reset.
- `S_AWADDR` in ADDR_WIDTH, `S_AWPROT` in 3 (ignored), `S_AWVALID` in 1, `S_AWREADY` out 1.
- `S_WDATA` in 32, `S_WSTRB` in 4, `S_WVALID` in 1, `S_WREADY` out 1.
- `S_BRESP` out 2, `S_BVALID` out 1, `S_BREADY` in 1.
- `S_ARADDR` in ADDR_WIDTH, `S_ARPROT` in 3 (ignored), `S_ARVALID` in 1, `S_ARREADY` out 1.
- `S_RDATA` out 32, `S_RRESP` out 2, `S_RVALID` out 1, `S_RLAST` out 1, `S_RREADY` in 1.

## Operation
- **Address decode**
  - An address is in range when `BASE_ADDR <= addr < BASE_ADDR + 4*MEM_DEPTH`.
  - Word index is `(addr - BASE_ADDR) >> 2`. Address bits [1:0] are ignored.
- **Write FSM**
  - States: W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP.
  - `AWREADY` is high in W_IDLE and W_HAVE_W.
  - `WREADY` is high in W_IDLE and W_HAVE_AW.
  - W_IDLE with an AW handshake only goes to W_HAVE_AW and latches the address.
  - W_IDLE with a W handshake only goes to W_HAVE_W and latches data and strobe.
  - W_IDLE with both handshakes in the same cycle goes directly to W_RESP.
  - W_HAVE_AW with a W handshake, or W_HAVE_W with an AW handshake, goes to W_RESP.
  - On entry to W_RESP:
    - An in-range address writes memory per byte lane (`WSTRB[i]` enables byte i) and sets `BRESP` = OKAY.
    - An out-of-range address leaves memory untouched and sets `BRESP` = SLVERR.
  - W_RESP holds `BVALID` until `BREADY` is sampled high, then returns to W_IDLE.
  - `WSTRB` = 0 is a legal no-op write and returns OKAY.
- **Read FSM**
  - States: R_IDLE (`ARREADY` = 1) and R_DATA (`RVALID` = 1, `ARREADY` = 0).
  - On an AR handshake, `RDATA` and `RRESP` are registered. Out-of-range reads return `RDATA` = 0 and SLVERR.
  - R_DATA holds `RDATA`/`RRESP` stable until `RREADY`, then returns to R_IDLE.
  - `RLAST` equals `RVALID`: every response is a single beat.
- **Read/write collision**
  - If a read samples the same word on the same edge that a write commits, the read returns the pre-write contents.
- **Response codes**: OKAY = 2'b00, SLVERR = 2'b10. EXOKAY and DECERR are never produced.

## Timing
- **Reset values** (asserted asynchronously while `ARESETN` is low):
  - All READY and VALID outputs are 0; `BRESP`, `RRESP` and `RDATA` are 0.
  - Memory is cleared to 0 and both FSMs go to idle.
- **Ready after reset**
  - A registered `init_done` flag sets on the first `ACLK` edge after `ARESETN` rises.
  - `AWREADY`, `WREADY` and `ARREADY` are gated by `init_done`, so they first go high one cycle after reset release.
- **Write latency**: `BVALID` rises on the edge after the later of the AW and W handshakes (same-cycle AW+W gives 1 cycle).
- **Read latency**: `RVALID` rises on the edge after the AR handshake.
- **Throughput**
  - After a B or R handshake, the corresponding READY reasserts one cycle later; there is no bypass.
  - Maximum rate is one write per 2 cycles and one read per 2 cycles.
- **Independence**: write and read paths operate concurrently with no mutual blocking.
- **Reset mid-transaction**: pending B and R responses and latched AW/W are discarded; no partial memory write occurs.
- **Stalled responses**: `BVALID`/`RVALID` are never withdrawn before their handshake, and payloads stay stable while stalled.

## Structure
- Package `axi_lite_pkg`:
  - `RESP_OKAY` and `RESP_SLVERR` constants.
  - `wr_state_t` and `rd_state_t` enums, shared with future AXI-Lite peripherals.
- One sub-module, `axi_lite_bytemem`:
  - MEM_DEPTH x 32 array with async clear.
  - One byte-enabled write port and one registered read port with read-old-data semantics.
- Top level holds address decode, both FSMs and `init_done`.

## Test plan
All scenarios use `BASE_ADDR` = 32'h0000_1000 and `MEM_DEPTH` = 256.
1. Same-cycle write:
   - Stimulus: AW = 0x1004 and W = 0xA000_0001, strobe 0xF, presented together with `BREADY` = 1.
   - Required: `BVALID` one cycle later with OKAY; a subsequent read of 0x1004 returns 0xA000_0001 with `RLAST` = 1.
2. W before AW:
   - Stimulus: W = 0xB000_0002 at cycle 0, then AW = 0x1008 at cycle 3.
   - Required: `WREADY` low during cycles 1-3; `BVALID` at cycle 4; read-back returns 0xB000_0002.
3. Partial-strobe write:
   - Stimulus: 0x1010 holds 0x1122_3344; write 0xFFFF_FFFF with strobe 0x5.
   - Required: read-back returns 0x11FF_33FF.
4. Out-of-range access:
   - Stimulus: write to 0x2000, then read 0x2000 and read 0x0FFC.
   - Required: BRESP = SLVERR; both reads return SLVERR with `RDATA` 0; memory unchanged.
5. Backpressure:
   - Stimulus: hold `BREADY` = 0 and `RREADY` = 0 for 5 cycles.
   - Required: `BVALID`/`RVALID` stay high with stable payloads; `AWREADY`/`WREADY`/`ARREADY` stay low; exactly one handshake occurs on release.
6. Reset mid-transaction:
   - Stimulus: assert `ARESETN` = 0 while in W_RESP and R_DATA.
   - Required: all outputs go to 0 asynchronously; after release, readies go high one cycle later and memory reads 0.
